// File: rtl/iter_muldiv.sv
// Radix-2 iterative multiply/divide unit: shift-add MULT/MULTU and restoring DIV/DIVU,
// one result bit per cycle, with flush (annul_i) and a pipeline stall request (busy_o).
//
// state  | meaning
// IDLE   | waiting for start_i; latches op, operand magnitudes and signs
// RUN    | one radix-2 step per cycle for WIDTH cycles
// DONE   | sign-corrected result registered, ready_o high for one cycle
module iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [1:0]           op_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 divzero_o,
    output logic                 busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               neg1_q, neg1_d;
    logic               neg2_q, neg2_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               divzero_q, divzero_d;

    logic               signed_op;
    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH:0]     add_hi;
    logic [2*WIDTH:0]   mul_tmp, mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   trial;
    logic               no_borrow;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH:0]   div_next, step_next;
    logic [2*WIDTH-1:0] prod, fix_mul, fix_div;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        signed_op = ~op_i[0];
        abs1 = (signed_op && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        abs2 = (signed_op && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

        // Multiply: acc = {partial product, remaining multiplier bits}
        add_hi   = acc_q[2*WIDTH:WIDTH] + {1'b0, b_q};
        mul_tmp  = acc_q[0] ? {add_hi, acc_q[WIDTH-1:0]} : acc_q;
        mul_next = {1'b0, mul_tmp[2*WIDTH:1]};

        // Divide: acc = {0, remainder, dividend/quotient}; shifted remainder needs WIDTH+1 bits
        rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
        trial     = {1'b0, rem_sh} - {2'b00, b_q};
        no_borrow = ~trial[WIDTH+1];
        rem_new   = no_borrow ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        div_next  = {1'b0, rem_new, acc_q[WIDTH-2:0], no_borrow};

        step_next = op_q[1] ? div_next : mul_next;

        prod    = step_next[2*WIDTH-1:0];
        quo     = step_next[WIDTH-1:0];
        rem     = step_next[2*WIDTH-1:WIDTH];
        fix_mul = (neg1_q ^ neg2_q) ? -prod : prod;
        fix_div = {(neg1_q ? -rem : rem), ((neg1_q ^ neg2_q) ? -quo : quo)};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg1_d    = neg1_q;
        neg2_d    = neg2_q;
        b_d       = b_q;
        acc_d     = acc_q;
        result_d  = result_q;
        divzero_d = divzero_q;

        case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    op_d   = op_i;
                    neg1_d = signed_op & opdata1_i[WIDTH-1];
                    neg2_d = signed_op & opdata2_i[WIDTH-1];
                    cnt_d  = '0;
                    if (op_i[1]) begin
                        b_d   = abs2;
                        acc_d = {{(WIDTH+1){1'b0}}, abs1};
                    end else begin
                        b_d   = abs1;
                        acc_d = {{(WIDTH+1){1'b0}}, abs2};
                    end
                    if (op_i[1] && (opdata2_i == '0)) begin
                        state_d   = S_DONE;
                        result_d  = {opdata1_i, {WIDTH{1'b1}}};
                        divzero_d = 1'b1;
                    end else begin
                        state_d   = S_RUN;
                        divzero_d = 1'b0;
                    end
                end
            end
            S_RUN: begin
                if (annul_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = step_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d  = S_DONE;
                        cnt_d    = '0;
                        result_d = op_q[1] ? fix_div : fix_mul;
                    end
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                divzero_d = 1'b0;
            end
            default: begin
                state_d   = S_IDLE;
                cnt_d     = '0;
                divzero_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= 2'b00;
            neg1_q    <= 1'b0;
            neg2_q    <= 1'b0;
            b_q       <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg1_q    <= neg1_d;
            neg2_q    <= neg2_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            divzero_q <= divzero_d;
        end
    end

    assign result_o  = result_q;
    assign ready_o   = (state_q == S_DONE);
    assign divzero_o = divzero_q;
    assign busy_o    = ((state_q == S_IDLE) & start_i & ~annul_i) | (state_q == S_RUN);

endmodule

// File: doc/iter_muldiv.md
# iter_muldiv

Parametrised iterative multiply/divide unit beside the EX stage. It replaces single-cycle HI/LO multiplication with a radix-2 engine (one bit per cycle) that supports signed and unsigned MULT and DIV. It holds the pipeline through a busy/stall request and returns a double-width {hi, lo} result to the EX stage for HI/LO write-back. A flush input cancels an operation that is in flight.

## Interface
- WIDTH, 32, operand width; even, ≥4; result is 2*WIDTH
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- start_i  in  1  request a new operation; sampled only in IDLE
- op_i  in  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU
- opdata1_i  in  WIDTH  multiplicand / dividend
- opdata2_i  in  WIDTH  multiplier / divisor
- annul_i  in  1  flush; cancels a pending or running operation
- result_o  out  2*WIDTH  mul: {product_hi, product_lo}; div: {remainder, quotient}
- ready_o  out  1  result valid, exactly one cycle per completed operation
- divzero_o  out  1  asserted with ready_o when the divisor was zero
- busy_o  out  1  stall request to pipeline control

## Operation
- States: IDLE, RUN, DONE.
- Reset (async, rst=0):
  - state=IDLE, counter=0.
  - result_o=0, ready_o=0, divzero_o=0, busy_o=0.
  - Takes effect immediately, including mid-operation.
- IDLE:
  - start_i=1 and annul_i=0 → latch op, latch operand magnitudes, counter=0.
  - For signed ops, each operand's magnitude is its two's-complement absolute value. Latch both sign bits.
  - For unsigned ops, operands are taken as-is.
  - DIV/DIVU with opdata2_i=0 → go directly to DONE with result {opdata1_i, all-ones}, divzero=1. No sign correction is applied.
  - Otherwise → RUN.
  - start_i with annul_i=1 is ignored.
- RUN, multiply: shift-add.
  - Each cycle, if multiplier LSB=1, add the multiplicand to the upper half of the 2*WIDTH+1-bit accumulator, then shift right 1.
- RUN, divide: restoring.
  - Each cycle, shift {rem, dividend} left 1. Trial-subtract the divisor from rem.
  - If no borrow, keep the difference and set the quotient bit to 1; otherwise set it to 0.
- RUN exit and flush:
  - counter increments each cycle. The cycle with counter=WIDTH-1 moves to DONE.
  - annul_i=1 in RUN → IDLE on the next edge. No ready_o. result_o unchanged.
- DONE: the registered, sign-corrected result is already on result_o.
  - ready_o=1 for this one cycle, then return to IDLE.
  - start_i in DONE is ignored; annul_i in DONE has no effect.
- Sign correction, applied on the RUN→DONE edge:
  - MULT: negate the 2*WIDTH product if the operand signs differ.
  - DIV: negate the quotient if the signs differ. The remainder takes the sign of the dividend.
  - Most-negative / -1 yields quotient = most-negative and remainder = 0 (wraps, no trap).
  - All arithmetic is modulo 2^WIDTH per half.
- result_o holds its value until the next accepted operation completes.
- divzero_o clears when ready_o clears.

## Timing
- Start accepted on edge E0, at the end of the start cycle.
- RUN occupies WIDTH cycles. ready_o is high in cycle WIDTH+1 after the start cycle: 33 for WIDTH=32.
- Divide-by-zero: ready_o is high in cycle 1 after the start cycle.
- busy_o is combinational and equals (IDLE & start_i & ~annul_i) | RUN.
  - It is high in the start cycle so EX stalls immediately.
  - It is low in DONE, so EX consumes result_o and advances in the ready_o cycle.
- Back-to-back: a new start_i is accepted in the IDLE cycle right after DONE. Minimum spacing is WIDTH+2 cycles.
- No combinational path from any input to result_o, ready_o or divzero_o.

## Test plan
- MULT, WIDTH=32, -3 × 7 → result_o=0xFFFFFFFF_FFFFFFEB. ready_o in cycle 33 only. busy_o high in cycles 0..32.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE_00000001. Then MULT 0x80000000 × 0x80000000 → 0x40000000_00000000.
- DIV -7 / 2 → {0xFFFFFFFF, 0xFFFFFFFD}. DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}. DIVU 100 / 7 → {2, 14}.
- DIVU 0x1234 / 0 → {0x00001234, 0xFFFFFFFF}, divzero_o=1 and ready_o=1 in cycle 1. busy_o low afterwards.
- annul_i in RUN cycle 10 → no ready_o, IDLE next cycle, result_o keeps the prior value. A following start completes correctly. start_i pulsed during RUN is ignored.
- rst low mid-RUN → all outputs 0 immediately. Repeat scenarios 1 and 3 with WIDTH=8: ready_o in cycle 9, -3×7 → 0xFFEB.
